// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// exec_pkg : opcode and FSM state encodings shared by the execute stage
// Rev 1.0
// ============================================================================
package exec_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_CMP = 4'd9,
    OP_MOV = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return op <= OP_MOV;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// shift_add_multiplier : iterative unsigned multiply, one partial product/cycle
// Rev 1.0
// ============================================================================
module shift_add_multiplier #(
  parameter int size_reg = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [size_reg-1:0]   a,
  input  logic [size_reg-1:0]   b,
  output logic                  done,
  output logic [2*size_reg-1:0] product
);

  localparam int CNT_W = $clog2(size_reg) + 1;

  logic [2*size_reg-1:0] mcand;
  logic [size_reg-1:0]   mplier;
  logic [CNT_W-1:0]      count;
  logic                  running;

  always_ff @(posedge clock) begin
    if (!reset) begin
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product <= '0;
        mcand   <= {{size_reg{1'b0}}, a};
        mplier  <= b;
        count   <= CNT_W'(size_reg);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CNT_W'(1);
        // done is raised together with the final accumulation
        if (count == CNT_W'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/exec_unit.sv
`default_nettype none
// ============================================================================
// exec_unit : execute stage with single-cycle ALU, iterative MUL, write-back
// Rev 1.0
// ============================================================================
module exec_unit
  import exec_pkg::*;
#(
  parameter int size_reg = 16,
  parameter int addr_reg = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [addr_reg-1:0] dest,
  input  logic [size_reg-1:0] op_a,
  input  logic [size_reg-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                write_reg,
  output logic [addr_reg-1:0] end_write,
  output logic [size_reg-1:0] write_data,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_c,
  output logic                flag_v
);

  localparam int SHW = $clog2(size_reg);
  localparam int MSB = size_reg - 1;

  state_e                state;
  logic [OPCODE_W-1:0]   op_q;
  logic [addr_reg-1:0]   dest_q;
  logic [size_reg-1:0]   a_q;
  logic [size_reg-1:0]   b_q;

  logic                  mul_start;
  logic                  mul_done;
  logic [2*size_reg-1:0] product;

  logic [size_reg:0]     sum;
  logic [size_reg:0]     diff;
  logic [size_reg:0]     shl_ext;
  logic [size_reg:0]     shr_ext;
  logic [SHW-1:0]        amt;
  logic [size_reg-1:0]   alu_res;
  logic                  alu_c;
  logic                  alu_v;
  logic                  alu_wr;

  // Multiplier loads straight from the ports on the accept edge
  assign mul_start = (state == IDLE) && start && (opcode == OP_MUL);

  shift_add_multiplier #(.size_reg(size_reg)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (product)
  );

  // Extra bit on each shift captures the last bit shifted out
  assign amt     = b_q[SHW-1:0];
  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign shl_ext = {1'b0, a_q} << amt;
  assign shr_ext = {a_q, 1'b0} >> amt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wr  = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[size_reg];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[MSB:0];
        alu_c   = diff[size_reg];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
        alu_wr  = (op_q != OP_CMP);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = shl_ext[MSB:0];
        alu_c   = shl_ext[size_reg];
      end
      OP_SHR: begin
        alu_res = shr_ext[size_reg:1];
        alu_c   = shr_ext[0];
      end
      OP_MOV: alu_res = b_q;
      default: alu_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= '0;
      dest_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      write_reg  <= 1'b0;
      end_write  <= '0;
      write_data <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
    end else begin
      done      <= 1'b0;
      illegal   <= 1'b0;
      write_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= opcode;
            dest_q <= dest;
            a_q    <= op_a;
            b_q    <= op_b;
            busy   <= 1'b1;
            state  <= (opcode == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          state     <= WB;
          done      <= 1'b1;
          illegal   <= !is_legal(op_q);
          write_reg <= alu_wr;
          if (alu_wr) begin
            end_write  <= dest_q;
            write_data <= alu_res;
          end
          if (is_legal(op_q)) begin
            flag_z <= (alu_res == '0);
            flag_n <= alu_res[MSB];
            flag_c <= alu_c;
            flag_v <= alu_v;
          end
        end
        MUL: begin
          if (mul_done) begin
            state      <= WB;
            done       <= 1'b1;
            write_reg  <= 1'b1;
            end_write  <= dest_q;
            write_data <= product[MSB:0];
            flag_z     <= (product[MSB:0] == '0);
            flag_n     <= product[MSB];
            flag_c     <= (product[2*size_reg-1:size_reg] != '0);
            flag_v     <= 1'b0;
          end
        end
        WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_exec_unit : vector table + scoreboard bench for exec_unit
// Rev 1.0
// ============================================================================
module tb_exec_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  dest = '0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy, done, illegal, write_reg;
  logic [1:0]  end_write;
  logic [15:0] write_data;
  logic        flag_z, flag_n, flag_c, flag_v;

  exec_unit #(.size_reg(16), .addr_reg(2)) dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode), .dest(dest),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .illegal(illegal),
    .write_reg(write_reg), .end_write(end_write), .write_data(write_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  dest;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        wr;
    logic        ill;
    logic [3:0]  zncv;
    int          lat;
  } vec_t;

  vec_t        tbl[18];
  vec_t        sb[$];
  int          total = 0;
  int          passed = 0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_dest = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] d, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] data, input logic wr,
                              input logic ill, input logic [3:0] zncv, input int lat);
    vec_t v;
    v.op = op; v.dest = d; v.a = a; v.b = b; v.data = data;
    v.wr = wr; v.ill = ill; v.zncv = zncv; v.lat = lat;
    return v;
  endfunction

  // Drive one operation; inject_k>0 pulses a competing start with new operands at that cycle
  task automatic run(input vec_t v, input int inject_k);
    vec_t e;
    int   lat;
    logic proto_ok;
    lat = 0;
    proto_ok = 1'b1;
    for (int w = 0; w < 40 && (busy || done); w++) @(negedge clock);
    opcode = v.op; dest = v.dest; op_a = v.a; op_b = v.b; start = 1'b1;
    sb.push_back(v);
    @(posedge clock);
    #1;
    start = 1'b0;
    opcode = 4'($urandom); dest = 2'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (k == inject_k) begin
        start = 1'b1; opcode = 4'd0; op_a = 16'hFFFF; op_b = 16'hFFFF;
      end else if (k == inject_k + 1) begin
        start = 1'b0;
      end
      if (!busy) proto_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (write_reg || illegal) proto_ok = 1'b0;
    end
    start = 1'b0;
    if (lat == 0) begin
      chk("done_timeout", 32'(lat), 32'(v.lat));
      void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("busy_protocol", 32'(proto_ok), 32'd1);
    chk("illegal", 32'(illegal), 32'(e.ill));
    chk("write_reg", 32'(write_reg), 32'(e.wr));
    chk("flags_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(e.zncv));
    if (e.wr) begin
      last_data = e.data;
      last_dest = e.dest;
    end
    chk("end_write", 32'(end_write), 32'(last_dest));
    chk("write_data", 32'(write_data), 32'(last_data));
  endtask

  initial begin
    tbl[0]  = mk(4'd0,  2'd2, 16'h7FFF, 16'h0001, 16'h8000, 1, 0, 4'b0101, 2);
    tbl[1]  = mk(4'd1,  2'd1, 16'h0003, 16'h0005, 16'hFFFE, 1, 0, 4'b0110, 2);
    tbl[2]  = mk(4'd15, 2'd3, 16'h0001, 16'h0001, 16'h0000, 0, 1, 4'b0110, 2);
    tbl[3]  = mk(4'd9,  2'd3, 16'h1234, 16'h1234, 16'h0000, 0, 0, 4'b1000, 2);
    tbl[4]  = mk(4'd2,  2'd0, 16'hF0F0, 16'h3C3C, 16'h3030, 1, 0, 4'b0000, 2);
    tbl[5]  = mk(4'd3,  2'd1, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1, 0, 4'b0100, 2);
    tbl[6]  = mk(4'd4,  2'd2, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 4'b1000, 2);
    tbl[7]  = mk(4'd5,  2'd3, 16'h00FF, 16'h1234, 16'hFF00, 1, 0, 4'b0100, 2);
    tbl[8]  = mk(4'd6,  2'd0, 16'h8001, 16'h0001, 16'h0002, 1, 0, 4'b0010, 2);
    tbl[9]  = mk(4'd7,  2'd1, 16'h8001, 16'h0000, 16'h8001, 1, 0, 4'b0100, 2);
    tbl[10] = mk(4'd7,  2'd2, 16'h0003, 16'h0011, 16'h0001, 1, 0, 4'b0010, 2);
    tbl[11] = mk(4'd6,  2'd3, 16'h0003, 16'h000F, 16'h8000, 1, 0, 4'b0110, 2);
    tbl[12] = mk(4'd10, 2'd0, 16'h5555, 16'h8000, 16'h8000, 1, 0, 4'b0100, 2);
    tbl[13] = mk(4'd0,  2'd1, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 4'b1010, 2);
    tbl[14] = mk(4'd11, 2'd2, 16'h1111, 16'h2222, 16'h0000, 0, 1, 4'b1010, 2);
    tbl[15] = mk(4'd1,  2'd2, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 4'b0001, 2);
    tbl[16] = mk(4'd8,  2'd3, 16'h0100, 16'h0100, 16'h0000, 1, 0, 4'b1010, 18);
    tbl[17] = mk(4'd8,  2'd0, 16'h00FF, 16'h0003, 16'h02FD, 1, 0, 4'b0000, 18);

    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", 32'({busy, done, illegal, write_reg, end_write, write_data,
                              flag_z, flag_n, flag_c, flag_v}), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    foreach (tbl[i]) run(tbl[i], 0);

    // Competing start and operand changes during a multiply must be ignored
    run(mk(4'd8, 2'd1, 16'h1234, 16'h0010, 16'h2340, 1, 0, 4'b0010, 18), 3);

    // Reset in the middle of a multiply aborts it with no write-back
    begin
      logic stray;
      stray = 1'b0;
      for (int w = 0; w < 40 && (busy || done); w++) @(negedge clock);
      opcode = 4'd8; dest = 2'd2; op_a = 16'h0007; op_b = 16'h0009; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (int k = 1; k <= 4; k++) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("midmul_reset_outputs", 32'({busy, done, illegal, write_reg, end_write, write_data,
                                       flag_z, flag_n, flag_c, flag_v}), 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clock);
        if (write_reg || done || busy) stray = 1'b1;
      end
      chk("midmul_no_writeback", 32'(stray), 32'd0);
      last_data = '0;
      last_dest = '0;
    end

    run(mk(4'd10, 2'd3, 16'h0000, 16'h00A5, 16'h00A5, 1, 0, 4'b0000, 2), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
